// File: rtl/pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pulse_conditioner
// Purpose  : Synchronise and debounce a raw heart pulse, apply a refractory
//            window, and emit one beat strobe plus beat-to-beat interval.
// Revision : 1.0
// ============================================================================
module pulse_conditioner #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_TICKS   = 8,
    parameter int REFRACTORY_TICKS = 488,
    parameter int TIMEOUT_TICKS    = 7320,
    parameter int CNT_W            = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             raw_pulse,
    output logic             beat,
    output logic [CNT_W-1:0] interval,
    output logic             interval_valid,
    output logic             no_signal
);

    localparam int c_DEB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int c_REF_W = (REFRACTORY_TICKS > 0) ? $clog2(REFRACTORY_TICKS + 1) : 1;

    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [c_REF_W-1:0] c_REF_LOAD = c_REF_W'(REFRACTORY_TICKS);
    localparam logic [CNT_W-1:0]   c_TIMEOUT  = CNT_W'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRACT = 2'd1,
        ARMED   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_level;
    logic [c_DEB_W-1:0]     r_deb_cnt;
    logic                   r_clean;
    logic                   r_clean_d;
    logic                   w_cand;

    state_t                 r_state,    w_state_nxt;
    logic [CNT_W-1:0]       r_cnt,      w_cnt_nxt;
    logic [c_REF_W-1:0]     r_ref,      w_ref_nxt;
    logic                   r_beat,     w_beat_nxt;
    logic                   r_iv,       w_iv_nxt;
    logic [CNT_W-1:0]       r_interval, w_interval_nxt;
    logic                   r_nosig,    w_nosig_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_pulse};
        end
    end

    assign w_sync_level = r_sync[SYNC_STAGES-1];

    // Clean level only moves after DEBOUNCE_TICKS consecutive disagreeing ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb_cnt <= '0;
            r_clean   <= 1'b0;
            r_clean_d <= 1'b0;
        end else begin
            r_clean_d <= r_clean;
            if (tick_en) begin
                if (w_sync_level != r_clean) begin
                    if (r_deb_cnt == c_DEB_LAST) begin
                        r_clean   <= ~r_clean;
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
                    end
                end else begin
                    r_deb_cnt <= '0;
                end
            end
        end
    end

    assign w_cand = r_clean & ~r_clean_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ref      <= '0;
            r_beat     <= 1'b0;
            r_iv       <= 1'b0;
            r_interval <= '0;
            r_nosig    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ref      <= w_ref_nxt;
            r_beat     <= w_beat_nxt;
            r_iv       <= w_iv_nxt;
            r_interval <= w_interval_nxt;
            r_nosig    <= w_nosig_nxt;
        end
    end

    // An accept overrides the free-running counter update, so a concurrent tick is dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ref_nxt      = r_ref;
        w_beat_nxt     = 1'b0;
        w_iv_nxt       = 1'b0;
        w_interval_nxt = r_interval;
        w_nosig_nxt    = r_nosig;

        if (tick_en && (r_cnt != c_TIMEOUT)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (tick_en && (r_ref != '0)) begin
            w_ref_nxt = r_ref - c_REF_W'(1);
        end

        case (r_state)
            IDLE: begin
                if (w_cand) begin
                    w_beat_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_ref_nxt   = c_REF_LOAD;
                    w_nosig_nxt = 1'b0;
                    w_state_nxt = REFRACT;
                end
            end
            REFRACT: begin
                if (r_cnt == c_TIMEOUT) begin
                    w_nosig_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_ref == '0) begin
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (w_cand) begin
                    w_beat_nxt     = 1'b1;
                    w_iv_nxt       = 1'b1;
                    w_interval_nxt = r_cnt;
                    w_cnt_nxt      = '0;
                    w_ref_nxt      = c_REF_LOAD;
                    w_state_nxt    = REFRACT;
                end else if (r_cnt == c_TIMEOUT) begin
                    w_nosig_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign beat           = r_beat;
    assign interval_valid = r_iv;
    assign interval       = r_interval;
    assign no_signal      = r_nosig;

endmodule
`default_nettype wire

// File: tb/tb_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_conditioner
// Purpose  : Randomised and directed checks of pulse_conditioner against a
//            tick-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_pulse_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 2;
    localparam int REFR = 10;
    localparam int TMO  = 50;
    localparam int W    = 13;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick_en = 1'b0;
    logic         raw_pulse = 1'b0;
    logic         beat;
    logic [W-1:0] interval;
    logic         interval_valid;
    logic         no_signal;

    int total = 0;
    int bad   = 0;

    pulse_conditioner #(
        .SYNC_STAGES      (SYNC),
        .DEBOUNCE_TICKS   (DEB),
        .REFRACTORY_TICKS (REFR),
        .TIMEOUT_TICKS    (TMO),
        .CNT_W            (W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_en        (tick_en),
        .raw_pulse      (raw_pulse),
        .beat           (beat),
        .interval       (interval),
        .interval_valid (interval_valid),
        .no_signal      (no_signal)
    );

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            tick_en = (ph == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: time measured in ticks since the last accepted beat.
    bit m_q[$];
    int m_deb, ticks_since;
    bit m_clean, m_cand, have_ref;
    bit m_beat, m_iv, m_nosig;
    int m_interval;
    bit prev_tick, prev_raw, prev_rst;

    int beat_cnt = 0;
    bit last_iv;
    int last_interval;

    task automatic model_reset();
        m_q = {};
        for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
        m_deb = 0; m_clean = 0; m_cand = 0; have_ref = 0; ticks_since = 0;
        m_beat = 0; m_iv = 0; m_nosig = 1; m_interval = 0;
    endtask

    task automatic model_step(input bit t, input bit r);
        bit s, cand, accepted;
        s = m_q[0];
        void'(m_q.pop_front());
        m_q.push_back(r);
        cand = m_cand;
        m_cand = 0;
        m_beat = 0; m_iv = 0; accepted = 0;
        if (cand && !have_ref) begin
            m_beat = 1; have_ref = 1; ticks_since = 0; m_nosig = 0; accepted = 1;
        end else if (cand && ticks_since > REFR) begin
            m_beat = 1; m_iv = 1; m_interval = ticks_since; ticks_since = 0; accepted = 1;
        end else if (have_ref && ticks_since >= TMO) begin
            m_nosig = 1; have_ref = 0;
        end
        if (!accepted && t && ticks_since < TMO) ticks_since++;
        if (t) begin
            if (s != m_clean) begin
                m_deb++;
                if (m_deb == DEB) begin
                    m_clean = !m_clean;
                    m_deb = 0;
                    if (m_clean) m_cand = 1;
                end
            end else begin
                m_deb = 0;
            end
        end
    endtask

    initial begin
        prev_rst = 0; prev_tick = 0; prev_raw = 0;
        model_reset();
    end

    always @(negedge clk) begin
        if (!(prev_rst && reset)) model_reset();
        else model_step(prev_tick, prev_raw);
        chk("beat", beat, m_beat);
        chk("interval_valid", interval_valid, m_iv);
        chk("interval", interval, m_interval);
        chk("no_signal", no_signal, m_nosig);
        if (beat === 1'b1) begin
            beat_cnt++;
            last_iv = interval_valid;
            last_interval = interval;
        end
        prev_tick = tick_en;
        prev_raw  = raw_pulse;
        prev_rst  = reset;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick_en) @(posedge clk);
        end
        #1;
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic short_pulse();
        raw_pulse = 1; wait_ticks(2);
        raw_pulse = 0; wait_ticks(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset held with a toggling input
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            raw_pulse = ~raw_pulse;
        end
        chk("rst_no_signal", no_signal, 1);
        chk("rst_interval", interval, 0);
        raw_pulse = 0;
        @(posedge clk); #1;
        reset = 1;
        wait_ticks(6);
        chk("post_reset_quiet", beat_cnt, 0);

        // One-tick glitch
        raw_pulse = 1; wait_ticks(1);
        raw_pulse = 0; wait_ticks(8);
        chk("glitch_no_beat", beat_cnt, 0);
        chk("glitch_no_signal", no_signal, 1);

        // Two beats 30 ticks apart
        raw_pulse = 1; wait_ticks(4);
        chk("first_beat", beat_cnt, 1);
        chk("first_no_iv", last_iv, 0);
        chk("first_no_signal", no_signal, 0);
        raw_pulse = 0; wait_ticks(26);
        raw_pulse = 1; wait_ticks(4);
        chk("second_beat", beat_cnt, 2);
        chk("second_iv", last_iv, 1);
        chk("interval_30", last_interval, 30);
        raw_pulse = 0; wait_ticks(16);
        short_pulse();
        chk("interval_20a", last_interval, 20);

        // Refractory: +5 ignored, +25 accepted
        wait_ticks(1);
        short_pulse();
        chk("refract_ignored", beat_cnt, 3);
        wait_ticks(16);
        short_pulse();
        chk("refract_beat", beat_cnt, 4);
        chk("interval_25", last_interval, 25);

        // Timeout
        wait_ticks(56);
        chk("timeout_no_signal", no_signal, 1);
        chk("timeout_interval_held", interval, 25);
        short_pulse();
        chk("after_timeout_beat", beat_cnt, 5);
        chk("after_timeout_no_iv", last_iv, 0);
        chk("after_timeout_signal", no_signal, 0);
        wait_ticks(16);
        short_pulse();
        chk("after_timeout_iv", last_iv, 1);
        chk("interval_20b", last_interval, 20);

        // Mid-operation reset
        wait_ticks(13);
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("async_rst_beat", beat, 0);
        chk("async_rst_iv", interval_valid, 0);
        chk("async_rst_interval", interval, 0);
        chk("async_rst_no_signal", no_signal, 1);
        wait_clks(3);
        reset = 1;
        wait_ticks(3);
        short_pulse();
        chk("post_rst_beat", beat_cnt, 7);
        chk("post_rst_no_iv", last_iv, 0);
        chk("post_rst_signal", no_signal, 0);

        // Randomised pulse trains, with occasional resets
        for (int i = 0; i < 200; i++) begin
            raw_pulse = 1;
            wait_ticks($urandom_range(1, 5));
            wait_clks($urandom_range(0, 3));
            raw_pulse = 0;
            wait_ticks($urandom_range(1, 60));
            wait_clks($urandom_range(0, 3));
            if (i % 37 == 36) begin
                reset = 0;
                wait_clks($urandom_range(1, 6));
                reset = 1;
            end
        end
        wait_ticks(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_conditioner.md
Name: pulse_conditioner

Overview:
- Front-end stage that sits directly upstream of the BPM averaging/display logic.
- Synchronises and debounces the raw heart-pulse input.
- Rejects re-triggers inside a refractory window and emits one clean single-cycle beat strobe per heartbeat.
- Measures the beat-to-beat interval in tick units (tick = 2.44 kHz enable) and flags loss of signal, so downstream averaging consumes intervals rather than a free-running counter.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the raw_pulse synchroniser (>=2).
- DEBOUNCE_TICKS, 8, consecutive ticks a new level must hold before the clean level changes (>=1).
- REFRACTORY_TICKS, 488, ticks after an accepted beat during which rising edges are ignored (0.2 s).
- TIMEOUT_TICKS, 7320, ticks without an accepted beat before no_signal asserts (3 s); must be < 2^CNT_W.
- CNT_W, 13, interval counter / output width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick_en  in  1  single-clk enable at tick rate
- raw_pulse  in  1  asynchronous sensor pulse
- beat  out  1  one-clk strobe per accepted beat
- interval  out  CNT_W  ticks between the last two accepted beats
- interval_valid  out  1  one-clk strobe, interval updated
- no_signal  out  1  level; high while no beat seen within timeout

Behaviour:
- Reset is asynchronous, active-low (reset=0) and clears all state. Values held during reset:
  - beat=0, interval_valid=0, interval=0, no_signal=1
  - state=IDLE, all counters 0
  - synchroniser and clean level = 0
- Synchroniser: raw_pulse passes through SYNC_STAGES flops on every clk, independent of tick_en.
- Debounce:
  - Counter compares the synchronised level against the clean level on tick_en only.
  - If they differ, the counter increments; if equal, it clears.
  - When the counter reaches DEBOUNCE_TICKS, the clean level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_TICKS ticks never reaches the clean level.
- Edge: a candidate is the clean level 0->1. The candidate is evaluated in the clk after the clean transition.
- Interval counter: increments on tick_en, saturates at TIMEOUT_TICKS.
- Refractory counter: loads REFRACTORY_TICKS on an accepted beat and decrements on tick_en to 0.
- FSM states:
  - IDLE: no reference beat. On candidate: beat=1, counter<=0, refractory loaded, no_signal<=0, go REFRACT. interval_valid stays 0.
  - REFRACT: candidates ignored, with no outputs and no counter reset. When the refractory count reaches 0, go ARMED.
  - ARMED: on candidate, accept it as follows, then go REFRACT:
    - beat=1, interval<=counter value before clear, interval_valid=1
    - counter<=0, refractory reloaded
- Timeout: in REFRACT or ARMED, when the counter reaches TIMEOUT_TICKS, no_signal<=1, go IDLE, interval holds its last value. Timeout takes priority over refractory expiry in the same cycle.
- Simultaneous candidate and tick_en in ARMED:
  - Accept takes priority; the counter clears to 0 and that tick is not counted.
  - The captured interval excludes the concurrent tick.
- Simultaneous candidate and timeout in ARMED: accept wins, no_signal stays 0.
- Strobe timing: beat and interval_valid are registered, high exactly one clk, aligned with each other. interval is stable from the interval_valid cycle until the next accept.
- Latency, raw rising edge to beat:
  - SYNC_STAGES clks, plus DEBOUNCE_TICKS ticks, plus 1 clk.
  - Identical for every beat, so the measured interval equals the raw spacing in ticks.

Test Plan (tick_en every 4 clks; DEBOUNCE_TICKS=2, REFRACTORY_TICKS=10, TIMEOUT_TICKS=50):
- Reset:
  - Stimulus: hold reset=0 with raw_pulse toggling.
  - Response: beat=0, interval_valid=0, interval=0, no_signal=1. After release, no outputs until a debounced edge.
- Glitch:
  - Stimulus: raw_pulse high for 1 tick.
  - Response: no beat, state stays IDLE, no_signal=1.
- Two beats:
  - Stimulus: clean pulses (high 4 ticks) with rising edges 30 ticks apart.
  - Response: first edge gives beat and no_signal->0 with no interval_valid. Second edge gives beat plus interval_valid with interval=30.
- Refractory:
  - Stimulus: after an accepted beat, a pulse rises at +5 ticks, another at +25 ticks.
  - Response: +5 gives no strobe. +25 gives beat and interval_valid with interval=25.
- Timeout:
  - Stimulus: after a beat, no pulses for 50 ticks.
  - Response: no_signal=1 and interval unchanged. Next pulse gives beat with no interval_valid and no_signal=0. The pulse after that, 20 ticks later, gives interval=20.
- Mid-operation reset:
  - Stimulus: assert reset 17 ticks after a beat, for 3 clks.
  - Response: outputs return to reset values immediately. The first post-reset pulse behaves as the IDLE first beat.
